// File: rtl/spectrum_peak_scan_if.sv
`default_nettype none
//============================================================================
// Module      : spectrum_peak_scan_if
// Description : Bundle between the spectrum peak scanner and its environment.
//               Carries the scan handshake (start/busy/done), the magnitude
//               RAM read port (rd_addr/rd_data) and the feature results.
//   slave  modport : the scanner (drives rd_addr, busy, done, results)
//   master modport : the environment (drives start and RAM read data)
// Revision    : 1.0 - initial release
//============================================================================
interface spectrum_peak_scan_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
);
    logic              start;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] carrier_bin;
    logic [DATA_W-1:0] carrier_mag;
    logic              sb_found;
    logic [ADDR_W-1:0] sb_bin;
    logic [DATA_W-1:0] sb_mag;
    logic [ADDR_W-1:0] sb_offset;
    logic [ADDR_W:0]   sig_count;
    logic [DATA_W+1:0] carrier_sum;

    modport slave (
        input  start, rd_data,
        output rd_addr, busy, done, carrier_bin, carrier_mag, sb_found,
               sb_bin, sb_mag, sb_offset, sig_count, carrier_sum
    );

    modport master (
        output start, rd_data,
        input  rd_addr, busy, done, carrier_bin, carrier_mag, sb_found,
               sb_bin, sb_mag, sb_offset, sig_count, carrier_sum
    );
endinterface
`default_nettype wire

// File: rtl/spectrum_peak_scan.sv
`default_nettype none
//============================================================================
// Module      : spectrum_peak_scan
// Description : Two-pass scan of the FFT magnitude RAM. Pass 1 finds the
//               carrier (maximum bin). Pass 2 re-reads a window around the
//               carrier to find the strongest sideband outside a guard zone
//               and counts bins above carrier_mag >> THR_SHIFT.
// Ports       : clk, rst_n (async, active low)
//               bus (spectrum_peak_scan_if.slave):
//                 start in, rd_data in, rd_addr out, busy/done out,
//                 carrier_bin/mag, sb_found/bin/mag/offset, sig_count,
//                 carrier_sum out
// Option      : CARRIER_SUM_EN - when defined, carrier_sum accumulates the
//               carrier bin and its two neighbours; otherwise it is tied 0.
// Revision    : 1.0 - initial release
//============================================================================
module spectrum_peak_scan #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 16,
    parameter int SEARCH_START = 1,
    parameter int SEARCH_END   = 2047,
    parameter int WIN          = 64,
    parameter int GUARD        = 2,
    parameter int THR_SHIFT    = 3,
    parameter int RD_LAT       = 2
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    spectrum_peak_scan_if.slave   bus
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_P1_RD    = 3'd1;
    localparam logic [2:0] S_P1_FLUSH = 3'd2;
    localparam logic [2:0] S_P2_RD    = 3'd3;
    localparam logic [2:0] S_P2_FLUSH = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    localparam int FCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int EW  = ADDR_W + 2;

    localparam logic [ADDR_W-1:0] SS_A    = ADDR_W'(SEARCH_START);
    localparam logic [ADDR_W-1:0] SE_A    = ADDR_W'(SEARCH_END);
    localparam logic [ADDR_W-1:0] WIN_A   = ADDR_W'(WIN);
    localparam logic [ADDR_W-1:0] GUARD_A = ADDR_W'(GUARD);
    localparam logic [EW-1:0]     SS_E    = EW'(SEARCH_START);
    localparam logic [EW-1:0]     SE_E    = EW'(SEARCH_END);
    localparam logic [EW-1:0]     WIN_E   = EW'(WIN);
    localparam logic [ADDR_W:0]   CNT_MAX = {(ADDR_W+1){1'b1}};
    localparam logic [FCW-1:0]    FL_LAST = FCW'(RD_LAT - 1);

    // ---------------- FSM state ----------------
    logic [2:0]     state_q, state_d;
    logic [FCW-1:0] flush_cnt_q;
    logic           flush_last;

    // FSM decoded outputs
    logic fsm_busy, fsm_done, issue, in_p1, in_p2, accept, p1_end, p2_end;

    // ---------------- datapath ----------------
    logic [ADDR_W-1:0] rd_addr_q;
    logic [RD_LAT-1:0] vld_q;
    logic [ADDR_W-1:0] adl_q [RD_LAT];
    logic              r_vld;
    logic [ADDR_W-1:0] r_addr;

    logic [DATA_W-1:0] max_mag_q, max_mag_d;
    logic [ADDR_W-1:0] max_bin_q, max_bin_d;

    logic [ADDR_W-1:0] cbin_q;
    logic [DATA_W-1:0] cmag_q;
    logic [DATA_W-1:0] thr_q;
    logic [ADDR_W-1:0] hi_q;
    logic [ADDR_W-1:0] lo_w, hi_w;
    logic [EW-1:0]     cext_w;

    logic [DATA_W-1:0] sbr_mag_q, sbr_mag_d;
    logic [ADDR_W-1:0] sbr_bin_q, sbr_bin_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0] dist_w;
    logic [ADDR_W-1:0] off_w;

    logic [ADDR_W-1:0] res_cbin_q, res_sbbin_q, res_off_q;
    logic [DATA_W-1:0] res_cmag_q, res_sbmag_q;
    logic              res_found_q;
    logic [ADDR_W:0]   res_cnt_q;

    assign flush_last = (flush_cnt_q == FL_LAST);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == S_P1_FLUSH || state_q == S_P2_FLUSH) && !flush_last)
                flush_cnt_q <= flush_cnt_q + FCW'(1);
            else
                flush_cnt_q <= '0;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (bus.start)            state_d = S_P1_RD;
            S_P1_RD:    if (rd_addr_q == SE_A)    state_d = S_P1_FLUSH;
            S_P1_FLUSH: if (flush_last)           state_d = S_P2_RD;
            S_P2_RD:    if (rd_addr_q == hi_q)    state_d = S_P2_FLUSH;
            S_P2_FLUSH: if (flush_last)           state_d = S_DONE;
            S_DONE:                               state_d = S_IDLE;
            default:                              state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        fsm_busy = (state_q != S_IDLE) && (state_q != S_DONE);
        fsm_done = (state_q == S_DONE);
        issue    = (state_q == S_P1_RD) || (state_q == S_P2_RD);
        in_p1    = (state_q == S_P1_RD) || (state_q == S_P1_FLUSH);
        in_p2    = (state_q == S_P2_RD) || (state_q == S_P2_FLUSH);
        accept   = (state_q == S_IDLE) && bus.start;
        p1_end   = (state_q == S_P1_FLUSH) && flush_last;
        p2_end   = (state_q == S_P2_FLUSH) && flush_last;
    end

    // Read data is paired with the address issued RD_LAT cycles earlier.
    assign r_vld  = vld_q[RD_LAT-1];
    assign r_addr = adl_q[RD_LAT-1];

    // Window bounds derived from the pass-1 result that is being finalised
    // this cycle, so pass 2 can start with no bubble. Comparisons are done
    // in a widened domain so the clamp never wraps.
    assign cext_w = {2'b00, max_bin_d};
    assign lo_w   = (cext_w < SS_E + WIN_E)  ? SS_A : max_bin_d - WIN_A;
    assign hi_w   = (cext_w + WIN_E > SE_E)  ? SE_A : max_bin_d + WIN_A;

    assign dist_w = (r_addr >= cbin_q) ? r_addr - cbin_q : cbin_q - r_addr;
    assign off_w  = (sbr_bin_d >= cbin_q) ? sbr_bin_d - cbin_q : cbin_q - sbr_bin_d;

    // Running maxima and counter. Strict '>' keeps the lowest index on ties
    // because bins are scanned in ascending order; the sideband max starts at
    // 0, so '>' also enforces mag > 0.
    always_comb begin
        max_mag_d = max_mag_q;
        max_bin_d = max_bin_q;
        sbr_mag_d = sbr_mag_q;
        sbr_bin_d = sbr_bin_q;
        cnt_d     = cnt_q;
        if (r_vld && in_p1 && (bus.rd_data > max_mag_q)) begin
            max_mag_d = bus.rd_data;
            max_bin_d = r_addr;
        end
        if (r_vld && in_p2 && (dist_w > GUARD_A)) begin
            if (bus.rd_data > sbr_mag_q) begin
                sbr_mag_d = bus.rd_data;
                sbr_bin_d = r_addr;
            end
            if ((bus.rd_data > thr_q) && (cnt_q != CNT_MAX))
                cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr_q   <= '0;
            vld_q       <= '0;
            for (int i = 0; i < RD_LAT; i++) adl_q[i] <= '0;
            max_mag_q   <= '0;
            max_bin_q   <= '0;
            cbin_q      <= '0;
            cmag_q      <= '0;
            thr_q       <= '0;
            hi_q        <= '0;
            sbr_mag_q   <= '0;
            sbr_bin_q   <= '0;
            cnt_q       <= '0;
            res_cbin_q  <= '0;
            res_cmag_q  <= '0;
            res_found_q <= 1'b0;
            res_sbbin_q <= '0;
            res_sbmag_q <= '0;
            res_off_q   <= '0;
            res_cnt_q   <= '0;
        end else begin
            // address delay line
            vld_q[0] <= issue;
            adl_q[0] <= rd_addr_q;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                adl_q[i] <= adl_q[i-1];
            end

            // read address generator; holds when not reading
            if (accept)
                rd_addr_q <= SS_A;
            else if (p1_end)
                rd_addr_q <= lo_w;
            else if ((state_q == S_P1_RD && rd_addr_q != SE_A) ||
                     (state_q == S_P2_RD && rd_addr_q != hi_q))
                rd_addr_q <= rd_addr_q + 1'b1;

            // pass 1
            if (accept) begin
                max_mag_q <= '0;
                max_bin_q <= SS_A;
            end else begin
                max_mag_q <= max_mag_d;
                max_bin_q <= max_bin_d;
            end

            // carrier latch and pass-2 initialisation
            if (p1_end) begin
                cbin_q    <= max_bin_d;
                cmag_q    <= max_mag_d;
                thr_q     <= max_mag_d >> THR_SHIFT;
                hi_q      <= hi_w;
                sbr_mag_q <= '0;
                sbr_bin_q <= max_bin_d;
                cnt_q     <= '0;
            end else begin
                sbr_mag_q <= sbr_mag_d;
                sbr_bin_q <= sbr_bin_d;
                cnt_q     <= cnt_d;
            end

            // results become visible in DONE and hold until the next DONE
            if (p2_end) begin
                res_cbin_q  <= cbin_q;
                res_cmag_q  <= cmag_q;
                res_found_q <= (sbr_mag_d != '0);
                res_sbbin_q <= sbr_bin_d;
                res_sbmag_q <= sbr_mag_d;
                res_off_q   <= off_w;
                res_cnt_q   <= cnt_d;
            end
        end
    end

`ifdef CARRIER_SUM_EN
    logic [DATA_W+1:0] sum_q, sum_d, res_sum_q;

    // Neighbours outside [lo,hi] are never read, so they add nothing.
    always_comb begin
        sum_d = sum_q;
        if (r_vld && in_p2 && (dist_w <= ADDR_W'(1)))
            sum_d = sum_q + (DATA_W+2)'(bus.rd_data);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q     <= '0;
            res_sum_q <= '0;
        end else begin
            if (p1_end) sum_q <= '0;
            else        sum_q <= sum_d;
            if (p2_end) res_sum_q <= sum_d;
        end
    end

    assign bus.carrier_sum = res_sum_q;
`else
    assign bus.carrier_sum = '0;
`endif

    assign bus.rd_addr     = rd_addr_q;
    assign bus.busy        = fsm_busy;
    assign bus.done        = fsm_done;
    assign bus.carrier_bin = res_cbin_q;
    assign bus.carrier_mag = res_cmag_q;
    assign bus.sb_found    = res_found_q;
    assign bus.sb_bin      = res_sbbin_q;
    assign bus.sb_mag      = res_sbmag_q;
    assign bus.sb_offset   = res_off_q;
    assign bus.sig_count   = res_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_spectrum_peak_scan.sv
`default_nettype none
//============================================================================
// Module      : tb_spectrum_peak_scan
// Description : Directed self-checking bench for spectrum_peak_scan with a
//               2-cycle-latency magnitude RAM model.
// Revision    : 1.0 - initial release
//============================================================================
module tb_spectrum_peak_scan;

    logic clk;
    logic rst_n;

    spectrum_peak_scan_if #(.ADDR_W(12), .DATA_W(16)) bus ();

    spectrum_peak_scan #(
        .ADDR_W(12), .DATA_W(16), .SEARCH_START(1), .SEARCH_END(2047),
        .WIN(64), .GUARD(2), .THR_SHIFT(3), .RD_LAT(2)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: data valid two cycles after the address
    logic [15:0] mem [4096];
    logic [15:0] ram_q1, ram_q2;
    always @(posedge clk) begin
        ram_q1 <= mem[bus.rd_addr];
        ram_q2 <= ram_q1;
    end
    assign bus.rd_data = ram_q2;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef CARRIER_SUM_EN
    localparam bit SUM_ON = 1'b1;
`else
    localparam bit SUM_ON = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 4096; i++) mem[i] = 16'd0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_carrier_bin"}, 32'(bus.carrier_bin), 0);
        check({tag, "_carrier_mag"}, 32'(bus.carrier_mag), 0);
        check({tag, "_sb_found"},    32'(bus.sb_found),    0);
        check({tag, "_sb_bin"},      32'(bus.sb_bin),      0);
        check({tag, "_sb_mag"},      32'(bus.sb_mag),      0);
        check({tag, "_sb_offset"},   32'(bus.sb_offset),   0);
        check({tag, "_sig_count"},   32'(bus.sig_count),   0);
        check({tag, "_carrier_sum"}, 32'(bus.carrier_sum), 0);
        check({tag, "_busy"},        32'(bus.busy),        0);
        check({tag, "_done"},        32'(bus.done),        0);
        check({tag, "_rd_addr"},     32'(bus.rd_addr),     0);
    endtask

    // Start pulse in cycle 0; cycle n is sampled 1 time unit after its
    // opening edge. An optional second start is raised in cycle dup_at.
    task automatic run_scan(input int dup_at, output int dcyc, output int ndone,
                            output int busy_err);
        dcyc = -1; ndone = 0; busy_err = 0;
        @(negedge clk);
        bus.start = 1'b1;
        for (int n = 1; n <= 3000; n++) begin
            @(posedge clk);
            #1;
            bus.start = (n == dup_at);
            if (bus.done) begin
                ndone++;
                if (dcyc < 0) dcyc = n;
            end
            if (bus.busy !== (dcyc < 0)) busy_err++;
            if (dcyc >= 0 && n >= dcyc + 5) break;
        end
        bus.start = 1'b0;
    endtask

    task automatic check_res(input string tag, input int cbin, input int cmag,
                             input int found, input int sbin, input int smag,
                             input int off, input int cnt, input int sum);
        check({tag, "_carrier_bin"}, 32'(bus.carrier_bin), cbin);
        check({tag, "_carrier_mag"}, 32'(bus.carrier_mag), cmag);
        check({tag, "_sb_found"},    32'(bus.sb_found),    found);
        check({tag, "_sb_bin"},      32'(bus.sb_bin),      sbin);
        check({tag, "_sb_mag"},      32'(bus.sb_mag),      smag);
        check({tag, "_sb_offset"},   32'(bus.sb_offset),   off);
        check({tag, "_sig_count"},   32'(bus.sig_count),   cnt);
        check({tag, "_carrier_sum"}, 32'(bus.carrier_sum), SUM_ON ? sum : 0);
    endtask

    int dcyc, ndone, berr;
    int dn_rst;

    initial begin
        rst_n     = 1'b0;
        bus.start = 1'b0;
        clear_mem();
        repeat (3) @(negedge clk);
        check_zero("rst_in");
        rst_n = 1'b1;
        @(negedge clk);
        check_zero("rst_out");

        // single carrier, no sidebands
        mem[500] = 16'd1000;
        run_scan(0, dcyc, ndone, berr);
        check("def_done_cycle", dcyc, 2181);
        check("def_done_count", ndone, 1);
        check("def_busy_err", berr, 0);
        check_res("def", 500, 1000, 0, 500, 0, 0, 0, 1000);

        // AM-like: symmetric sidebands plus a bin inside the guard zone
        clear_mem();
        mem[500] = 16'd1000; mem[490] = 16'd300; mem[510] = 16'd300; mem[501] = 16'd900;
        run_scan(0, dcyc, ndone, berr);
        check("am_done_cycle", dcyc, 2181);
        check_res("am", 500, 1000, 1, 490, 300, 10, 2, 1900);

        // window clamped at the low edge: lo=1, hi=84
        clear_mem();
        mem[20] = 16'd800; mem[5] = 16'd200;
        run_scan(0, dcyc, ndone, berr);
        check("edge_done_cycle", dcyc, 2136);
        check("edge_busy_err", berr, 0);
        check_res("edge", 20, 800, 1, 5, 200, 15, 1, 800);

        // tie: lowest index wins; a start while busy is ignored
        clear_mem();
        mem[100] = 16'd800; mem[200] = 16'd800;
        run_scan(5, dcyc, ndone, berr);
        check("tie_done_cycle", dcyc, 2181);
        check("tie_done_count", ndone, 1);
        check("tie_busy_err", berr, 0);
        check_res("tie", 100, 800, 0, 100, 0, 0, 0, 800);

        // asynchronous reset in the middle of pass 1
        clear_mem();
        mem[499] = 16'd50; mem[500] = 16'd1000; mem[501] = 16'd60;
        @(negedge clk);
        bus.start = 1'b1;
        for (int n = 1; n <= 1000; n++) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
        check("mid_busy_before", 32'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        check_zero("mid_rst");
        dn_rst = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (bus.done) dn_rst++;
        end
        check("mid_no_done", dn_rst, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // full scan after reset release; carrier with guarded neighbours
        run_scan(0, dcyc, ndone, berr);
        check("post_done_cycle", dcyc, 2181);
        check("post_done_count", ndone, 1);
        check_res("post", 500, 1000, 0, 500, 0, 0, 0, 1110);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spectrum_peak_scan.md
Name: spectrum_peak_scan

Overview:
- Downstream of the FFT magnitude RAM (4096x16, filled by the RAM write controller, which pulses wr_done when full).
- Scans the stored magnitude spectrum in two passes. Pass 1 finds the carrier peak. Pass 2 finds the strongest sideband near the carrier and counts significant bins.
- Produces the features that modulation classification and parameter estimation (ma, mf, F) consume, all in the 50 MHz FFT domain.

Parameters:
ADDR_W, 12, RAM address width
DATA_W, 16, magnitude width
SEARCH_START, 1, first bin scanned (skips DC)
SEARCH_END, 2047, last bin scanned (positive half spectrum)
WIN, 64, pass-2 half-window in bins around carrier
GUARD, 2, bins each side of carrier excluded from sideband search
THR_SHIFT, 3, significance threshold = carrier_mag >> THR_SHIFT
RD_LAT, 2, RAM read latency in cycles (addrb to doutb)

Ports:
clk  in  1  system clock (clk_50m)
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begin scan (driven from wr_done)
rd_addr  out  ADDR_W  RAM read address
rd_data  in  DATA_W  RAM read data, valid RD_LAT cycles after rd_addr
busy  out  1  high from cycle after accepted start until done
done  out  1  one-cycle pulse; results valid and held
carrier_bin  out  ADDR_W  index of maximum magnitude
carrier_mag  out  DATA_W  magnitude at carrier_bin
sb_found  out  1  a nonzero sideband exists in the window
sb_bin  out  ADDR_W  index of strongest sideband
sb_mag  out  DATA_W  its magnitude
sb_offset  out  ADDR_W  |sb_bin - carrier_bin|
sig_count  out  ADDR_W+1  window bins (guard excluded) with mag > threshold
carrier_sum  out  DATA_W+2  see Optional Feature

Behaviour:
- Reset: all outputs 0, FSM in IDLE. Reset is asynchronous and may assert mid-scan; the scan aborts, no done is issued, and held results are cleared to 0.
- States: IDLE -> P1_RD -> P1_FLUSH -> P2_RD -> P2_FLUSH -> DONE -> IDLE.
- IDLE: start sampled high -> P1_RD. start while busy is ignored.
- P1_RD: issue addresses SEARCH_START..SEARCH_END, one per cycle.
  - Data is paired with its address via an RD_LAT-deep address delay line.
  - Running max uses strict greater-than, so on a tie the lowest index wins.
- P1_FLUSH: RD_LAT cycles to absorb outstanding reads. Then latch carrier_bin/mag and compute thr = carrier_mag >> THR_SHIFT.
- P2_RD: issue lo..hi, where lo = max(SEARCH_START, carrier_bin-WIN) and hi = min(SEARCH_END, carrier_bin+WIN). Clamp with signed/extended arithmetic; no wrap-around.
  - Bins with |k - carrier_bin| <= GUARD are skipped for the sideband max and for sig_count.
  - Sideband max uses strict greater-than with mag > 0 (lowest index wins on a tie).
  - sig_count increments on mag > thr, saturating at 2^(ADDR_W+1)-1.
- P2_FLUSH: RD_LAT cycles.
- DONE: drive results, pulse done for 1 cycle, clear busy, return to IDLE.
- No sideband found: sb_found=0, sb_bin=carrier_bin, sb_mag=0, sb_offset=0.
- rd_addr holds its last value when not reading.
- Result outputs update only at DONE and are held until the next DONE or reset.
- Latency, with start sampled in cycle 0: done in cycle (SEARCH_END-SEARCH_START+1) + RD_LAT + (hi-lo+1) + RD_LAT + 1.
- All-zero spectrum: carrier_bin=SEARCH_START, carrier_mag=0, thr=0, sig_count=0, sb_found=0.

Optional Feature:
- Macro CARRIER_SUM_EN.
- Defined: during pass 2, carrier_sum accumulates mag at carrier_bin-1, carrier_bin and carrier_bin+1. Neighbours outside [lo,hi] contribute 0. The value is latched at DONE.
- Undefined: carrier_sum is driven constant 0 and no accumulator is built.

Test Plan:
- Defaults. RAM all 0 except bin 500=1000; start pulse in cycle 0 -> done only in cycle 2181; carrier_bin=500, carrier_mag=1000, sb_found=0, sig_count=0, busy high cycles 1..2180.
- AM: bin 500=1000, 490=300, 510=300, 501=900 (guard) -> sb_bin=490, sb_mag=300, sb_offset=10, sig_count=2.
- Edge: bin 20=800, bin 5=200 -> window lo=1, hi=84; done in cycle 2047+2+84+2+1=2136; sb_bin=5, sb_offset=15, sig_count=1.
- Tie: bins 100 and 200 both 800 -> carrier_bin=100. A second start pulse during busy -> ignored, exactly one done.
- Assert rst_n low in cycle 1000 of pass 1 -> all outputs 0 immediately, no done. New start after release -> normal full scan.
- CARRIER_SUM_EN: bins 499=50, 500=1000, 501=60 -> carrier_sum=1110. Without the macro -> carrier_sum=0.
